// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS-style main control FSM: Moore decode of state (and mem_ready)
// into datapath controls, plus a registered illegal-opcode pulse.
module main_control_fsm (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       alu_src_a,
   output logic [1:0] pc_source,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [3:0] state,
   output logic       illegal_op
);

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXECUTE   = 4'd6,
      R_WB      = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9,
      ADDI_EXEC = 4'd10,
      ADDI_WB   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   state_t cur_state;
   state_t eff_state;
   logic   illegal_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state <= FETCH;
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= 1'b0;
         case (cur_state)
            FETCH:     if (mem_ready) cur_state <= DECODE;
            DECODE: begin
               case (opcode)
                  OP_RTYPE:     cur_state <= EXECUTE;
                  OP_LW, OP_SW: cur_state <= MEM_ADDR;
                  OP_BEQ:       cur_state <= BRANCH;
                  OP_J:         cur_state <= JUMP;
                  OP_ADDI:      cur_state <= ADDI_EXEC;
                  default: begin
                     cur_state <= FETCH;
                     illegal_q <= 1'b1;
                  end
               endcase
            end
            MEM_ADDR:  cur_state <= (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  if (mem_ready) cur_state <= MEM_WB;
            MEM_WRITE: if (mem_ready) cur_state <= FETCH;
            EXECUTE:   cur_state <= R_WB;
            ADDI_EXEC: cur_state <= ADDI_WB;
            default:   cur_state <= FETCH;
         endcase
      end
   end

   // While reset is held the outputs look like FETCH regardless of the register.
   assign eff_state  = rst ? FETCH : cur_state;
   assign state      = eff_state;
   assign illegal_op = illegal_q & ~rst;

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      alu_src_a     = 1'b0;
      pc_source     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      case (eff_state)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         DECODE:    alu_src_b = 2'b11;
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         MEM_READ: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         MEM_WRITE: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
         end
         JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         ADDI_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         ADDI_WB:   reg_write = 1'b1;
         default: ;
      endcase
   end

endmodule
